// File: rtl/tcdm_shim_pkg.sv
// Shared types and helpers for the TCDM master shim: request/response payloads and the
// rule deciding whether a request will be answered by the interconnect.
package tcdm_shim_pkg;

    localparam int unsigned ShimAddrWidth = 32;
    localparam int unsigned ShimDataWidth = 32;
    localparam int unsigned ShimBeWidth   = ShimDataWidth / 8;

    typedef struct packed {
        logic [ShimAddrWidth-1:0] add;
        logic                     we_n;
        logic [ShimDataWidth-1:0] wdata;
        logic [ShimBeWidth-1:0]   be;
    } req_t;

    typedef struct packed {
        logic [ShimDataWidth-1:0] rdata;
        logic                     we_n;
    } resp_t;

    // Loads are always answered; stores only when the interconnect returns write responses.
    function automatic logic needs_resp(input logic we_n, input bit write_resp_on);
        return ~we_n | write_resp_on;
    endfunction

endpackage

// File: rtl/tcdm_master_shim_if.sv
// Core-side request/response channels and interconnect req/gnt/vld channel of one initiator.
// Signal names carry direction suffixes as seen from the shim.
interface tcdm_master_shim_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8
) ();

    // Core request channel
    logic                 c_valid_i;
    logic                 c_ready_o;
    logic [AddrWidth-1:0] c_add_i;
    logic                 c_we_n_i;
    logic [DataWidth-1:0] c_wdata_i;
    logic [BeWidth-1:0]   c_be_i;

    // Core response channel
    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [DataWidth-1:0] r_rdata_o;
    logic                 r_we_n_o;

    // Interconnect side
    logic                 req_o;
    logic [AddrWidth-1:0] add_o;
    logic                 we_n_o;
    logic [DataWidth-1:0] wdata_o;
    logic [BeWidth-1:0]   be_o;
    logic                 gnt_i;
    logic                 vld_i;
    logic [DataWidth-1:0] rdata_i;

    modport master (
        input  c_valid_i, c_add_i, c_we_n_i, c_wdata_i, c_be_i, r_ready_i, gnt_i, vld_i, rdata_i,
        output c_ready_o, r_valid_o, r_rdata_o, r_we_n_o, req_o, add_o, we_n_o, wdata_o, be_o
    );

    modport slave (
        output c_valid_i, c_add_i, c_we_n_i, c_wdata_i, c_be_i, r_ready_i, gnt_i, vld_i, rdata_i,
        input  c_ready_o, r_valid_o, r_rdata_o, r_we_n_o, req_o, add_o, we_n_o, wdata_o, be_o
    );

endinterface

// File: rtl/tcdm_shim_resp_fifo.sv
// Small circular FIFO with synchronous active-low reset and an occupancy count.
// Push and pop may coincide at any occupancy, including full.
module tcdm_shim_resp_fifo #(
    parameter type         entry_t = logic,
    parameter int unsigned Depth   = 4,
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW   = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  entry_t          data_i,
    input  logic            pop_i,
    output entry_t          data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    entry_t          mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
        if (push_ok) wptr_d = ptr_inc(wptr_q);
        if (pop_ok)  rptr_d = ptr_inc(rptr_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/tcdm_master_shim.sv
// Per-initiator adapter: core valid/ready requests to interconnect req/gnt, fixed-latency
// responses into a credit-protected FIFO. Perf counters under TCDM_MASTER_SHIM_PERF_EN.
module tcdm_master_shim
    import tcdm_shim_pkg::*;
#(
    parameter int unsigned AddrWidth   = ShimAddrWidth,
    parameter int unsigned DataWidth   = ShimDataWidth,
    parameter int unsigned BeWidth     = DataWidth / 8,
    parameter int unsigned RespDepth   = 4,
    parameter bit          WriteRespOn = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    tcdm_master_shim_if.master bus,
    output logic               err_o
`ifdef TCDM_MASTER_SHIM_PERF_EN
    ,
    output logic [31:0]        perf_stall_o,
    output logic [31:0]        perf_credit_o
`endif
);

    localparam int unsigned CntW = $clog2(RespDepth) + 1;
    localparam int unsigned SumW = CntW + 2;

    req_t            req_q, req_d;
    logic            req_valid_q, req_valid_d;
    logic            accept, grant, reg_needs, credit_ok;
    logic [CntW-1:0] outstanding, fifo_count;
    logic [SumW-1:0] reserved;

    logic            tag_push, tag_pop, tag_we_n, tag_full, tag_empty;
    logic            resp_push, resp_pop, resp_full, resp_empty;
    resp_t           resp_in, resp_out;
    logic            err_q;
    logic            unused_full;

    assign unused_full = tag_full ^ resp_full;

    // A slot is held from acceptance until the response leaves the FIFO: while in the
    // request register, while outstanding at the interconnect, and while queued.
    assign grant     = req_valid_q & bus.gnt_i;
    assign reg_needs = req_valid_q & needs_resp(req_q.we_n, WriteRespOn);
    assign reserved  = SumW'(outstanding) + SumW'(fifo_count) + SumW'(reg_needs);
    assign credit_ok = (reserved < SumW'(RespDepth));

    assign bus.c_ready_o = rst_ni & credit_ok & (~req_valid_q | bus.gnt_i);
    assign accept        = bus.c_valid_i & bus.c_ready_o;

    always_comb begin
        req_valid_d = req_valid_q;
        req_d       = req_q;
        if (accept) begin
            req_valid_d = 1'b1;
            req_d.add   = bus.c_add_i;
            req_d.we_n  = bus.c_we_n_i;
            req_d.wdata = bus.c_wdata_i;
            req_d.be    = bus.c_be_i;
        end else if (grant) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
        end
    end

    assign bus.req_o   = req_valid_q;
    assign bus.add_o   = req_q.add;
    assign bus.we_n_o  = req_q.we_n;
    assign bus.wdata_o = req_q.wdata;
    assign bus.be_o    = req_q.be;

    // Tag FIFO occupancy is the outstanding count; its entries order load/store flags.
    assign tag_push = grant & needs_resp(req_q.we_n, WriteRespOn);
    assign tag_pop  = bus.vld_i & ~tag_empty;

    tcdm_shim_resp_fifo #(
        .entry_t (logic),
        .Depth   (RespDepth)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tag_push),
        .data_i  (req_q.we_n),
        .pop_i   (tag_pop),
        .data_o  (tag_we_n),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (outstanding)
    );

    always_comb begin
        resp_in.rdata = tag_we_n ? '0 : bus.rdata_i;
        resp_in.we_n  = tag_we_n;
    end

    assign resp_push = tag_pop;
    assign resp_pop  = ~resp_empty & bus.r_ready_i;

    tcdm_shim_resp_fifo #(
        .entry_t (resp_t),
        .Depth   (RespDepth)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (resp_push),
        .data_i  (resp_in),
        .pop_i   (resp_pop),
        .data_o  (resp_out),
        .full_o  (resp_full),
        .empty_o (resp_empty),
        .count_o (fifo_count)
    );

    assign bus.r_valid_o = ~resp_empty;
    assign bus.r_rdata_o = resp_out.rdata;
    assign bus.r_we_n_o  = resp_out.we_n;

    // Unexpected response (nothing outstanding, e.g. after a reset): dropped, flagged sticky.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (bus.vld_i & tag_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

`ifdef TCDM_MASTER_SHIM_PERF_EN
    logic [31:0] perf_stall_q, perf_credit_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_stall_q  <= '0;
            perf_credit_q <= '0;
        end else begin
            if (req_valid_q & ~bus.gnt_i & ~&perf_stall_q) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (bus.c_valid_i & ~credit_ok & ~&perf_credit_q) begin
                perf_credit_q <= perf_credit_q + 32'd1;
            end
        end
    end

    assign perf_stall_o  = perf_stall_q;
    assign perf_credit_o = perf_credit_q;
`endif

endmodule

// File: tb/tb_tcdm_master_shim.sv
// Bench for tcdm_master_shim: directed scenarios then random traffic against a queue-based
// model with a memory-backed interconnect. Perf checks under TCDM_MASTER_SHIM_PERF_EN.
module tb_tcdm_master_shim;

    localparam int unsigned Depth = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic err, err_nw;
    always #5 clk = ~clk;

    tcdm_master_shim_if bus ();
    tcdm_master_shim_if bus_nw ();

`ifdef TCDM_MASTER_SHIM_PERF_EN
    logic [31:0] perf_stall, perf_credit, perf_stall_nw, perf_credit_nw;
`endif

    tcdm_master_shim #(
        .RespDepth   (Depth),
        .WriteRespOn (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .err_o         (err)
`ifdef TCDM_MASTER_SHIM_PERF_EN
        ,
        .perf_stall_o  (perf_stall),
        .perf_credit_o (perf_credit)
`endif
    );

    tcdm_master_shim #(
        .RespDepth   (Depth),
        .WriteRespOn (1'b0)
    ) dut_nw (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus_nw),
        .err_o         (err_nw)
`ifdef TCDM_MASTER_SHIM_PERF_EN
        ,
        .perf_stall_o  (perf_stall_nw),
        .perf_credit_o (perf_credit_nw)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        we_n;
    } item_t;

    typedef struct {
        logic [31:0] add;
        logic        we_n;
        logic [31:0] wdata;
        logic [3:0]  be;
    } creq_t;

    int checks = 0;
    int errors = 0;

    // Model: requests accepted but not granted, interconnect deliveries pending, responses queued.
    creq_t       req_q[$];
    item_t       ic_q[$];
    item_t       resp_q[$];
    int          out_cnt = 0;
    bit          err_exp = 0;
    logic [31:0] mem [16];
    int          perf_stall_exp = 0;
    int          perf_credit_exp = 0;

    bit          s_valid, s_we_n, s_gnt, s_ready, s_hold;
    logic [31:0] s_add, s_wdata;
    logic [3:0]  s_be;
    int          acc_seen;
    logic        obs_we[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit    vld, gnt_drv, exp_req, exp_rdy, credit;
        int    reserved;
        item_t it;
        creq_t g;
        int    idx;
        gnt_drv = s_gnt && rst_n;
        vld     = rst_n && (ic_q.size() > 0) && !s_hold;
        bus.c_valid_i = s_valid;
        bus.c_add_i   = s_add;
        bus.c_we_n_i  = s_we_n;
        bus.c_wdata_i = s_wdata;
        bus.c_be_i    = s_be;
        bus.r_ready_i = s_ready;
        bus.gnt_i     = gnt_drv;
        bus.vld_i     = vld;
        bus.rdata_i   = vld ? ic_q[0].data : $urandom();
        #4;
        reserved = out_cnt + resp_q.size() + req_q.size();
        credit   = reserved < Depth;
        exp_req  = req_q.size() > 0;
        exp_rdy  = rst_n && credit && (!exp_req || gnt_drv);
        chk("req_o", bus.req_o, exp_req);
        chk("c_ready_o", bus.c_ready_o, exp_rdy);
        chk("r_valid_o", bus.r_valid_o, resp_q.size() > 0);
        chk("err", err, err_exp);
        if (exp_req) begin
            chk("add_o", bus.add_o, req_q[0].add);
            chk("we_n_o", bus.we_n_o, req_q[0].we_n);
            chk("wdata_o", bus.wdata_o, req_q[0].wdata);
            chk("be_o", bus.be_o, req_q[0].be);
        end
        if (resp_q.size() > 0) begin
            chk("r_rdata_o", bus.r_rdata_o, resp_q[0].data);
            chk("r_we_n_o", bus.r_we_n_o, resp_q[0].we_n);
        end
`ifdef TCDM_MASTER_SHIM_PERF_EN
        chk("perf_stall_o", perf_stall, perf_stall_exp);
        chk("perf_credit_o", perf_credit, perf_credit_exp);
`endif
        if (bus.c_valid_i && bus.c_ready_o) acc_seen++;
        if (bus.r_valid_o && s_ready && rst_n) obs_we.push_back(bus.r_we_n_o);
        if (!rst_n) begin
            req_q.delete();
            resp_q.delete();
            out_cnt = 0;
            err_exp = 0;
            perf_stall_exp = 0;
            perf_credit_exp = 0;
        end else begin
            if (exp_req && !gnt_drv) perf_stall_exp++;
            if (s_valid && !credit) perf_credit_exp++;
            if (resp_q.size() > 0 && s_ready) void'(resp_q.pop_front());
            if (vld) begin
                it = ic_q.pop_front();
                if (out_cnt > 0) begin
                    out_cnt--;
                    resp_q.push_back('{it.we_n ? 32'h0 : it.data, it.we_n});
                end else begin
                    err_exp = 1;
                end
            end
            if (exp_req && gnt_drv) begin
                g   = req_q.pop_front();
                idx = int'(g.add[5:2]);
                if (g.we_n) begin
                    for (int b = 0; b < 4; b++) if (g.be[b]) mem[idx][8*b +: 8] = g.wdata[8*b +: 8];
                    ic_q.push_back('{$urandom(), 1'b1});
                end else begin
                    ic_q.push_back('{mem[idx], 1'b0});
                end
                out_cnt++;
            end
            if (s_valid && exp_rdy) req_q.push_back('{s_add, s_we_n, s_wdata, s_be});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit valid, input bit we_n, input logic [31:0] add);
        s_valid = valid;
        s_we_n  = we_n;
        s_add   = add;
        s_wdata = $urandom();
        s_be    = 4'($urandom_range(15));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom();
        set_req(0, 0, 0);
        s_gnt = 0; s_ready = 1; s_hold = 0;
        bus_nw.c_valid_i = 0; bus_nw.c_add_i = 0; bus_nw.c_we_n_i = 1; bus_nw.c_wdata_i = 0;
        bus_nw.c_be_i = 0; bus_nw.r_ready_i = 1; bus_nw.gnt_i = 0; bus_nw.vld_i = 0;
        bus_nw.rdata_i = 0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Single load, granted immediately, answered next cycle.
        mem[4] = 32'hDEADBEEF;
        s_gnt = 1;
        set_req(1, 0, 32'h10);
        cycle();
        set_req(0, 0, 0);
        repeat (5) cycle();

        // Grant withheld for three cycles while another request waits.
        s_gnt = 0;
        set_req(1, 1, 32'h24);
        cycle();
        set_req(1, 0, 32'h08);
        repeat (3) cycle();
        s_gnt = 1;
        repeat (2) cycle();
        set_req(0, 0, 0);
        repeat (5) cycle();

        // Credit exhaustion with the response channel blocked.
        s_ready  = 0;
        acc_seen = 0;
        for (int k = 0; k < 8; k++) begin
            set_req(1, 0, 32'(k * 4));
            cycle();
        end
        chk("fill_accepts", 64'(acc_seen), 64'd4);
        s_ready = 1;
        cycle();
        s_ready = 0;
        cycle();
        set_req(0, 0, 0);
        s_ready = 1;
        repeat (8) cycle();

        // Stores without write responses on the second instance.
        bus_nw.gnt_i = 1;
        for (int k = 0; k < 8; k++) begin
            bus_nw.c_valid_i = 1; bus_nw.c_we_n_i = 1;
            bus_nw.c_add_i = 32'(k * 4); bus_nw.c_wdata_i = $urandom(); bus_nw.c_be_i = 4'hF;
            #4;
            chk("nw_c_ready", bus_nw.c_ready_o, 1'b1);
            chk("nw_req", bus_nw.req_o, k > 0);
            chk("nw_r_valid", bus_nw.r_valid_o, 1'b0);
            @(posedge clk);
            #1;
        end
        bus_nw.c_valid_i = 1; bus_nw.c_we_n_i = 0; bus_nw.c_add_i = 32'h40;
        @(posedge clk);
        #1;
        bus_nw.c_valid_i = 0;
        @(posedge clk);
        #1;
        bus_nw.vld_i = 1; bus_nw.rdata_i = 32'h1234_5678;
        #4;
        chk("nw_r_valid_before", bus_nw.r_valid_o, 1'b0);
        @(posedge clk);
        #1;
        bus_nw.vld_i = 0;
        #4;
        chk("nw_r_valid", bus_nw.r_valid_o, 1'b1);
        chk("nw_r_we_n", bus_nw.r_we_n_o, 1'b0);
        chk("nw_r_rdata", bus_nw.r_rdata_o, 32'h1234_5678);
        chk("nw_err", err_nw, 1'b0);
        @(posedge clk);
        #1;
        #4;
        chk("nw_r_valid_after", bus_nw.r_valid_o, 1'b0);
        @(posedge clk);
        #1;

        // Interleaved load/store/load to one word.
        obs_we.delete();
        set_req(1, 0, 32'h20);
        cycle();
        set_req(1, 1, 32'h20);
        cycle();
        set_req(1, 0, 32'h20);
        cycle();
        set_req(0, 0, 0);
        repeat (6) cycle();
        chk("ilv_count", 64'(obs_we.size()), 64'd3);
        if (obs_we.size() == 3) begin
            chk("ilv_we0", obs_we[0], 1'b0);
            chk("ilv_we1", obs_we[1], 1'b1);
            chk("ilv_we2", obs_we[2], 1'b0);
        end

        // Reset with two responses outstanding and one queued; late responses follow.
        s_ready = 0;
        s_hold  = 1;
        for (int k = 0; k < 3; k++) begin
            set_req(1, 0, 32'(k * 4 + 32'h30));
            cycle();
        end
        set_req(0, 0, 0);
        cycle();
        s_hold = 0;
        cycle();
        s_hold = 1;
        rst_n  = 0;
        cycle();
        rst_n = 1;
        cycle();
        s_hold = 0;
        repeat (3) cycle();
        chk("late_err", err, 1'b1);
        s_ready = 1;

        // Random traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            set_req($urandom_range(9) < 6, $urandom_range(1) == 1, $urandom());
            s_ready = $urandom_range(3) != 0;
            s_hold  = ($urandom_range(3) == 0) && (ic_q.size() == out_cnt);
            s_gnt   = ($urandom_range(3) != 0) && (ic_q.size() == out_cnt);
            rst_n   = $urandom_range(149) != 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
